// File: rtl/alu_result_pipe_mux.sv
// alu_result_pipe_mux
//   Selects one of NUM_IN ALU result lanes (WIDTH data bits plus a carry bit at
//   position WIDTH) by binary opcode. The chosen result is registered behind a
//   valid/ready handshake with a 2-entry skid buffer (output register + skid).
//   in_ready depends on state only, so there is no combinational path from
//   out_ready back to the upstream stage.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   In_bus              NUM_IN concatenated lanes, lane k at [k*(WIDTH+1) +: WIDTH+1]
//   opcode, in_valid    lane select and upstream valid
//   in_ready            block can accept this cycle (= !skid_valid)
//   Out, out_valid      registered result and its valid
//   out_ready           downstream accepts Out
//   sel_err             registered with Out; opcode was >= NUM_IN
//   op_count            accepted-operation counter, wraps at 2**CNT_W
//   zero_flag           only when ALU_MUX_FLAGS_EN is defined: data bits all zero
// Optional feature macro: ALU_MUX_FLAGS_EN

// Per-lane match: passes the lane through only when the opcode selects it, so
// the lane pick is an AND-OR tree and an out-of-range opcode yields zero.
module alu_mux_lane #(
  parameter int DW       = 33,
  parameter int SEL_W    = 4,
  parameter int LANE_IDX = 0
) (
  input  logic [DW-1:0]    lane_i,
  input  logic [SEL_W-1:0] opcode_i,
  output logic [DW-1:0]    masked_o
);
  assign masked_o = (opcode_i == SEL_W'(LANE_IDX)) ? lane_i : '0;
endmodule

module alu_result_pipe_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 16,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IN*(WIDTH+1)-1:0] In_bus,
  input  logic [SEL_W-1:0]          opcode,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH:0]            Out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err,
`ifdef ALU_MUX_FLAGS_EN
  output logic                      zero_flag,
`endif
  output logic [CNT_W-1:0]          op_count
);
  localparam int DW = WIDTH + 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
`ifdef ALU_MUX_FLAGS_EN
    logic          zf;
`endif
  } res_t;

  // ---- selection ----
  logic [NUM_IN-1:0][DW-1:0] lane_masked;
  logic [DW-1:0]             sel_data;
  res_t                      sel_r;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_lane
    alu_mux_lane #(.DW(DW), .SEL_W(SEL_W), .LANE_IDX(k)) u_lane (
      .lane_i   (In_bus[k*DW +: DW]),
      .opcode_i (opcode),
      .masked_o (lane_masked[k])
    );
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) sel_data = sel_data | lane_masked[k];
    sel_r      = '0;
    sel_r.data = sel_data;
    sel_r.err  = (32'(opcode) >= 32'(NUM_IN));
`ifdef ALU_MUX_FLAGS_EN
    // carry bit excluded; an error result never reports zero
    sel_r.zf   = ~sel_r.err & (sel_data[WIDTH-1:0] == '0);
`endif
  end

  // ---- state ----
  res_t             out_q, out_d, skid_q, skid_d;
  logic             out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, drain;

  assign in_ready = ~skid_vld_q;
  assign accept   = in_valid & in_ready;
  assign drain    = out_vld_q & out_ready;

  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = accept ? cnt_q + CNT_W'(1) : cnt_q;
    if (!out_vld_q || drain) begin
      // skid entry is older than any new input; accept cannot coincide with it
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_d     = sel_r;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = sel_r;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign Out       = out_q.data;
  assign sel_err   = out_q.err;
  assign out_valid = out_vld_q;
  assign op_count  = cnt_q;
`ifdef ALU_MUX_FLAGS_EN
  assign zero_flag = out_q.zf;
`endif
endmodule

// File: tb/tb_alu_result_pipe_mux.sv
module tb_alu_result_pipe_mux;
  localparam int WIDTH = 32, NUM_IN = 12, SEL_W = 4, DW = WIDTH + 1;

  logic                 clk = 0, rst = 1;
  logic [NUM_IN*DW-1:0] In_bus = '0;
  logic [SEL_W-1:0]     opcode = '0;
  logic                 in_valid = 0, out_ready = 0;
  logic                 in_ready, out_valid, sel_err, in_ready4, out_valid4, sel_err4;
  logic [WIDTH:0]       Out, Out4;
  logic [15:0]          op_count;
  logic [3:0]           op_count4;
`ifdef ALU_MUX_FLAGS_EN
  logic                 zero_flag, zero_flag4;
`endif

  always #5 clk = ~clk;

  alu_result_pipe_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .In_bus(In_bus), .opcode(opcode), .in_valid(in_valid),
    .in_ready(in_ready), .Out(Out), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err),
`ifdef ALU_MUX_FLAGS_EN
    .zero_flag(zero_flag),
`endif
    .op_count(op_count));

  // narrow-counter instance, used for the wrap check only
  alu_result_pipe_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .In_bus(In_bus), .opcode(opcode), .in_valid(in_valid),
    .in_ready(in_ready4), .Out(Out4), .out_valid(out_valid4), .out_ready(out_ready),
    .sel_err(sel_err4),
`ifdef ALU_MUX_FLAGS_EN
    .zero_flag(zero_flag4),
`endif
    .op_count(op_count4));

  typedef struct packed { logic [DW-1:0] d; logic e; } exp_t;

  int   tests = 0, fails = 0;
  int   mcnt = 0;
  exp_t exp_q[$];
  logic [DW-1:0] cur_lanes [NUM_IN];
  logic [3:0]    cur_op = '0;
  logic          done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // ---- reference model + scoreboard monitor ----
  logic          have_prev = 0;
  logic [DW-1:0] prev_out;
  logic          prev_err;

  always @(negedge clk) begin
    int   held;
    exp_t e;
    if (rst) begin
      have_prev = 0;
    end else begin
      held = exp_q.size();   // results currently inside the block
      chk("out_valid", {63'd0, out_valid}, {63'd0, held > 0});
      chk("in_ready", {63'd0, in_ready}, {63'd0, held < 2});
      chk("op_count", {48'd0, op_count}, 64'(mcnt % 65536));
      chk("op_count_w4", {60'd0, op_count4}, 64'(mcnt % 16));
      if (have_prev && out_valid) begin
        chk("stable_out", {31'd0, Out}, {31'd0, prev_out});
        chk("stable_err", {63'd0, sel_err}, {63'd0, prev_err});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", {31'd0, Out}, {31'd0, e.d});
          chk("sel_err", {63'd0, sel_err}, {63'd0, e.e});
`ifdef ALU_MUX_FLAGS_EN
          chk("zero_flag", {63'd0, zero_flag}, {63'd0, !e.e && (e.d[WIDTH-1:0] == 0)});
`endif
        end
      end
      have_prev = out_valid && !out_ready;
      prev_out  = Out;
      prev_err  = sel_err;
      if (in_valid && in_ready) begin
        if (cur_op < NUM_IN) begin e.d = cur_lanes[cur_op]; e.e = 1'b0; end
        else                 begin e.d = '0;                e.e = 1'b1; end
        exp_q.push_back(e);
        mcnt++;
      end
    end
  end

  // ---- driver ----
  task automatic send(input logic [3:0] op, input logic [DW-1:0] v);
    int   n = 0;
    logic acc;
    for (int k = 0; k < NUM_IN; k++) begin
      cur_lanes[k] = {$urandom_range(0, 1) == 1, $urandom()};
      if ($urandom_range(0, 7) == 0) cur_lanes[k][WIDTH-1:0] = '0;
    end
    if (op < NUM_IN) cur_lanes[op] = v;
    for (int k = 0; k < NUM_IN; k++) In_bus[k*DW +: DW] = cur_lanes[k];
    cur_op = op; opcode = op; in_valid = 1;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 100);
    if (!acc) chk("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic idle();
    in_valid = 0;
  endtask

  task automatic rnd_send();
    send(4'($urandom_range(0, 15)), {$urandom_range(0, 1) == 1, $urandom()});
  endtask

  initial begin
    int snap;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_out", {31'd0, Out}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_op_count", {48'd0, op_count}, 64'd0);
    chk("rst_sel_err", {63'd0, sel_err}, 64'd0);

    // first transaction, 1-cycle latency
    out_ready = 1;
    send(4'd3, 33'h0_DEADBEEF); idle();
    chk("first_out", {31'd0, Out}, 64'h0_DEADBEEF);
    chk("first_valid", {63'd0, out_valid}, 64'd1);
    chk("first_cnt", {48'd0, op_count}, 64'd1);

    // out-of-range opcode
    send(4'd15, 33'h1_FFFFFFFF); idle();
    chk("oor_out", {31'd0, Out}, 64'd0);
    chk("oor_err", {63'd0, sel_err}, 64'd1);
    @(posedge clk); #1;

    // stall: A, B fill the pipe, C waits until out_ready rises
    out_ready = 0;
    send(4'd0, 33'd1);
    send(4'd1, 33'd2);
    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    chk("stall_out_held", {31'd0, Out}, 64'd1);
    fork
      begin send(4'd2, 33'd3); idle(); end
      begin repeat (3) @(posedge clk); #1 out_ready = 1; end
    join
    repeat (4) @(posedge clk); #1;

    // zero carry-only lane
    send(4'd5, 33'h1_00000000); idle();
    chk("zf_out", {31'd0, Out}, 64'h1_00000000);
    @(posedge clk); #1;

    // streaming 100 results at full rate
    snap = mcnt;
    for (int i = 0; i < 100; i++) rnd_send();
    idle();
    chk("stream_count", {48'd0, op_count}, 64'(snap + 100));
    @(posedge clk); #1;

    // random backpressure
    done = 0;
    fork
      begin for (int i = 0; i < 200; i++) rnd_send(); idle(); done = 1; end
      begin while (!done) begin out_ready = ($urandom_range(0, 2) != 0); @(posedge clk); #1; end end
    join
    out_ready = 1;
    repeat (4) @(posedge clk); #1;
    chk("drained", {63'd0, out_valid}, 64'd0);

    // reset while stalled with skid full
    out_ready = 0;
    send(4'd1, 33'h7); send(4'd2, 33'h8); idle();
    chk("pre_rst_full", {63'd0, in_ready}, 64'd0);
    rst = 1; exp_q.delete(); mcnt = 0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_op_count", {48'd0, op_count}, 64'd0);
    chk("arst_out", {31'd0, Out}, 64'd0);
    @(posedge clk); @(posedge clk); #1 rst = 0;
    out_ready = 1;
    send(4'd4, 33'h0_12345678); idle();
    chk("post_rst_out", {31'd0, Out}, 64'h0_12345678);
    repeat (3) @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_result_pipe_mux.md
Name: alu_result_pipe_mux

Overview:
- Parametrised successor to the flat 16:1 ALU result selector.
- Selects one of NUM_IN result lanes, each WIDTH+1 bits wide (bit WIDTH is the carry/overflow lane), using a binary opcode.
- Registers the chosen result behind a valid/ready handshake with a 2-entry skid buffer.
- Sits between the ALU functional units and the writeback stage, so the EX/WB boundary can stall without losing results.

Parameters:
- WIDTH, 32, data width; each lane and the output carry WIDTH+1 bits, bit WIDTH being carry.
- NUM_IN, 16, number of result lanes; legal range 2..16.
- SEL_W, 4, opcode width; must satisfy 2**SEL_W >= NUM_IN.
- CNT_W, 16, width of the accepted-operation counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- In_bus  input  NUM_IN*(WIDTH+1)  concatenated lanes; lane k occupies bits [k*(WIDTH+1) +: WIDTH+1].
- opcode  input  SEL_W  lane select, sampled with in_valid.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  block can accept this cycle.
- Out  output  WIDTH+1  registered selected result.
- out_valid  output  1  Out holds a valid result.
- out_ready  input  1  downstream accepts Out this cycle.
- sel_err  output  1  registered with Out; 1 when opcode >= NUM_IN.
- op_count  output  CNT_W  number of accepted operations.
- zero_flag  output  1  present only with ALU_MUX_FLAGS_EN.

Behaviour:
- Selection:
  - Combinational lane pick: sel = lane[opcode].
  - opcode >= NUM_IN gives sel = 0 and err = 1.
  - No X propagation from an out-of-range opcode.
- Storage: output register {Out, sel_err, out_valid} plus one skid register {skid_data, skid_err, skid_valid}.
- in_ready = !skid_valid. Purely a function of state; no combinational path from out_ready.
- Accept: accept = in_valid & in_ready. Drain: drain = out_valid & out_ready.
- Per-cycle update, in priority order:
  - Output register empty, or draining:
    - If skid_valid: Out <= skid_data, out_valid <= 1, skid_valid <= 0. A simultaneous accept is impossible because in_ready = 0.
    - Else if accept: Out <= sel, out_valid <= 1.
    - Else: out_valid <= 0.
  - Output register full and not draining:
    - If accept: skid <= sel, skid_valid <= 1.
    - Out is held stable.
- Latency: 1 cycle from accept to out_valid when the pipe is empty. Throughput is 1 result per cycle while out_ready = 1.
- Stability: while out_valid = 1 and out_ready = 0, Out and sel_err do not change.
- Ordering: results leave in strict acceptance order.
- Counter: op_count increments by 1 on every accept and wraps from 2**CNT_W-1 to 0. It also counts accepts with sel_err = 1.
- Reset, applied immediately and asynchronously:
  - Out = 0, sel_err = 0, out_valid = 0.
  - skid_valid = 0, skid_data = 0, op_count = 0.
  - in_ready = 1 after reset.
  - Any in-flight results are discarded; no partial transfer survives.
- Boundary cases:
  - Skid full and out_ready = 0: in_ready = 0, and in_valid is ignored.
  - Skid full and out_ready = 1: the skid entry moves to Out and in_ready returns to 1 in the next cycle.

Optional Feature:
- Macro: ALU_MUX_FLAGS_EN.
- Defined:
  - zero_flag port exists, registered alongside Out.
  - zero_flag = 1 when the selected data bits [WIDTH-1:0] are all 0; the carry bit is excluded.
  - zero_flag is carried through the skid path with its result.
  - zero_flag is 0 when sel_err = 1 and 0 on reset.
- Undefined: no zero_flag port and no flag logic; all other behaviour is identical.

Test Plan:
- Reset, then in_valid=1 with opcode=3, lane3=33'h0_DEADBEEF and out_ready=1 -> next cycle Out=33'h0_DEADBEEF, out_valid=1, sel_err=0, op_count=1.
- opcode=15 with NUM_IN=12 -> Out=0, sel_err=1, op_count increments, zero_flag=0 (flags build).
- Hold out_ready=0 and send A=1 then B=2 back-to-back -> Out=1 held, in_ready=0 after the second accept, and a third item C is not accepted. Raise out_ready -> Out sequence is 1, 2, then C, with no loss or duplication.
- Stream 100 results with out_ready=1 -> 100 output beats in order, one per cycle after 1-cycle latency, op_count=100.
- Set CNT_W=4 and accept 17 operations -> op_count = 1 (wrapped).
- Assert rst mid-stall with the skid full -> out_valid=0, skid cleared, in_ready=1, op_count=0, Out=0 immediately.
- Flags build: select a lane holding 33'h1_00000000 -> zero_flag=1 and Out[32]=1.
